// File: rtl/serial_compliment_if.sv
// Operand/result bundle for the serial two's complementer.
// SERIAL_TAP_EN adds the serial tap (ser_out/ser_valid) to the bundle.
interface serial_compliment_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             done;
`ifdef SERIAL_TAP_EN
    logic             ser_out;
    logic             ser_valid;

    modport master (
        output data_in,
        input  data_out,
        input  done,
        input  ser_out,
        input  ser_valid
    );

    modport slave (
        input  data_in,
        output data_out,
        output done,
        output ser_out,
        output ser_valid
    );
`else
    modport master (
        output data_in,
        input  data_out,
        input  done
    );

    modport slave (
        input  data_in,
        output data_out,
        output done
    );
`endif
endinterface

// File: rtl/serial_compliment.sv
// Serial two's complementer: shifts a loaded word LSB-first, negating it.
// Optional macro SERIAL_TAP_EN exposes the per-shift result bit stream.
module serial_compliment #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 set,
    serial_compliment_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_FULL = CW'(WIDTH);

    logic [WIDTH-1:0] r_sr;
    logic             r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    logic             w_b;
    logic             w_r;
    logic             w_busy;
    logic             w_last;

    // Bits below the first 1 pass unchanged; every later bit is inverted.
    assign w_b    = r_sr[0];
    assign w_r    = w_b ^ r_q;
    assign w_busy = (r_cnt < C_FULL);
    assign w_last = (r_cnt == C_LAST);

`ifdef SERIAL_TAP_EN
    logic r_ser;
    logic r_ser_valid;

    // Load on set low, shift one bit per edge until WIDTH bits are done.
    always_ff @(posedge clk) begin
        if (!set) begin
            r_sr        <= bus.data_in;
            r_q         <= 1'b0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_ser       <= 1'b0;
            r_ser_valid <= 1'b0;
        end else if (w_busy) begin
            r_sr        <= {w_r, r_sr[WIDTH-1:1]};
            r_q         <= r_q | w_b;
            r_cnt       <= r_cnt + 1'b1;
            r_done      <= w_last;
            r_ser       <= w_r;
            r_ser_valid <= 1'b1;
        end else begin
            r_ser_valid <= 1'b0;
        end
    end

    assign bus.ser_out   = r_ser;
    assign bus.ser_valid = r_ser_valid;
`else
    // Load on set low, shift one bit per edge until WIDTH bits are done.
    always_ff @(posedge clk) begin
        if (!set) begin
            r_sr   <= bus.data_in;
            r_q    <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (w_busy) begin
            r_sr   <= {w_r, r_sr[WIDTH-1:1]};
            r_q    <= r_q | w_b;
            r_cnt  <= r_cnt + 1'b1;
            r_done <= w_last;
        end
    end
`endif

    assign bus.data_out = r_sr;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_serial_compliment.sv
// Scoreboard bench for serial_compliment (WIDTH=4).
// Build with +define+SERIAL_TAP_EN to also check the serial tap.
module tb_serial_compliment;
    localparam int W = 4;

    logic clk;
    logic set;
    int   total;
    int   bad;

    logic [W-1:0] sb[$];

    serial_compliment_if #(.WIDTH(W)) bus ();

    serial_compliment #(.WIDTH(W)) dut (
        .clk (clk),
        .set (set),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load d with set low for one edge, then shift to completion.
    task automatic run_op(input logic [W-1:0] d);
        logic [W-1:0] e;
        logic [W-1:0] r;
        int           n;
        logic         got;
        set         = 1'b0;
        bus.data_in = d;
        step();
        chk("load_data", 32'(bus.data_out), 32'(d));
        chk("load_done", 32'(bus.done), 0);
        e = ~d + 1'b1;
        sb.push_back(e);
        set = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 3 * W) begin
            bus.data_in = W'($urandom);
            step();
            n++;
`ifdef SERIAL_TAP_EN
            if (n <= W) begin
                chk("tap_valid", 32'(bus.ser_valid), 1);
                chk("tap_bit", 32'(bus.ser_out), 32'(e[n-1]));
            end
`endif
            if (bus.done)
                got = 1'b1;
        end
        chk("timeout", 32'(got), 1);
        chk("latency", 32'(n), W);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("result", 32'(bus.data_out), 32'(r));
        end else begin
            r = e;
            chk("sb_empty", 32'(sb.size()), 1);
        end
        repeat (5) begin
            bus.data_in = W'($urandom);
            step();
            chk("hold_data", 32'(bus.data_out), 32'(r));
            chk("hold_done", 32'(bus.done), 1);
`ifdef SERIAL_TAP_EN
            chk("hold_valid", 32'(bus.ser_valid), 0);
`endif
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        set         = 1'b0;
        bus.data_in = '0;
        step();
        step();

        run_op(4'b1010);
        run_op(4'b0011);
        run_op(4'b0110);
        run_op(4'b1000);
        run_op(4'b0000);
        run_op(4'b0001);
        run_op(4'b1111);

        // Abort after two shifts, reload, and expect the new operand's result.
        set         = 1'b0;
        bus.data_in = 4'b1010;
        step();
        set = 1'b1;
        step();
        step();
        chk("mid_done", 32'(bus.done), 0);
        set         = 1'b0;
        bus.data_in = 4'b0011;
        step();
        chk("abort_data", 32'(bus.data_out), 32'h3);
        chk("abort_done", 32'(bus.done), 0);
        set         = 1'b0;
        bus.data_in = 4'b0110;
        step();
        chk("reload_data", 32'(bus.data_out), 32'h6);
        run_op(4'b0011);

        for (int i = 0; i < 6; i++)
            run_op(W'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_compliment.md
Name: serial_compliment

Overview:
- Serial two's complementer: a WIDTH-bit shift register plus one "seen-a-one" flip-flop.
- While in reset, the block loads a parallel word. After reset releases, it shifts the word LSB-first for WIDTH cycles and replaces each bit with its two's-complement bit.
- When done, the register holds -data_in mod 2^WIDTH on the parallel output.
- Used as a small arithmetic helper where area matters more than latency.

Parameters:
- WIDTH, 4, word width in bits (legal range ≥2).

Ports:
- clk  input  1  rising-edge clock.
- set  input  1  reset: synchronous, active-low. While low, the parallel load/initialise is performed.
- data_in  input  WIDTH  parallel operand. Sampled only on edges where set==0.
- data_out  output  WIDTH  shift-register contents. Holds the result once done==1.
- done  output  1  high once WIDTH shifts have completed. Stays high until the next reset.

Behaviour:
- Internal state:
  - sr[WIDTH-1:0], the shift register.
  - q, the flip-flop meaning "a 1 has already passed".
  - cnt, counting 0..WIDTH, width $clog2(WIDTH+1).
  - done.
- Rising edge with set==0 (reset/load):
  - sr<=data_in, q<=0, cnt<=0, done<=0.
  - data_out therefore equals data_in one edge after the load edge.
  - Holding set low on consecutive edges keeps reloading, so data_in tracks into sr.
- Rising edge with set==1 and cnt<WIDTH (shift step):
  - b=sr[0]; r=b^q.
  - sr<={r, sr[WIDTH-1:1]} (result enters at MSB, shifts right).
  - q<=q|b.
  - cnt<=cnt+1.
  - done<=1 when cnt==WIDTH-1 (i.e., on the WIDTH-th shift edge).
- Rising edge with set==1 and cnt==WIDTH:
  - Hold all state. No further shifting; data_out and done are stable.
- Latency: exactly WIDTH clock edges after the first edge with set==1.
  - On that edge data_out = (~data_in + 1) mod 2^WIDTH and done=1.
- Intermediate data_out values during shifting are partial. Consumers must qualify data_out with done.
- Boundary cases:
  - data_in=0 → result 0. q never sets.
  - data_in=100..0 (most-negative value) → result equals input. No overflow flag.
- Reset mid-operation: set low on any edge aborts the operation and reloads immediately. Reset has priority over shifting.
- data_in changes while set==1 are ignored.
- No combinational path from inputs to outputs. All outputs are registered.
- Power-up state before the first reset is undefined. The bench must apply set=0 for at least one edge.

Optional Feature:
- Macro SERIAL_TAP_EN.
- When defined, add two registered outputs:
  - ser_out (1 bit): the r bit produced on the last shift edge.
  - ser_valid (1 bit): high exactly on the edges where a shift occurred. Cleared on reset and after done.
- This allows streaming the complement LSB-first to a downstream serial consumer.
- When not defined, neither port exists, and data_out/done behaviour is identical in both builds.

Test Plan:
- WIDTH=4, data_in=4'b1010: set=0 for one edge, then set=1 for 4 edges → data_out=4'b0110, done=1 on 4th edge; holds thereafter.
- data_in=4'b0011, same sequence → 4'b1101; data_in=4'b0110 → 4'b1010.
- Boundary: data_in=4'b1000 → 4'b1000; data_in=4'b0000 → 4'b0000; done=1 after 4 edges in both.
- Reset mid-operation: load 4'b1010, shift 2 edges, set=0 with data_in=4'b0011 → next edge data_out=4'b0011, done=0; 4 more shifts → 4'b1101.
- Hold: after done, 5 extra edges with set=1 and data_in toggling → data_out and done unchanged. Under SERIAL_TAP_EN for 4'b1010, ser_out sequence is 0,1,1,0 with ser_valid high for exactly 4 edges.
